// File: rtl/rc4_xor_stream.sv
// rc4_xor_stream
// Combines RC4 keystream bytes with plaintext bytes to produce ciphertext,
// one byte per cycle at full throughput.
//
// Keystream bytes from the PRGA stage land in a small FIFO. That FIFO stays
// filled across messages, so the PRGA can run ahead. A message is framed by
// a start pulse carrying its length. Each plaintext byte is XORed with the
// FIFO head and presented on a registered ciphertext output with
// valid/ready flow control.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a message (sampled in IDLE only)
//   msg_len    in   [7:0] message length, latched on accepted start
//   flush      in   discard all buffered keystream
//   ks_valid   in   keystream byte valid
//   ks_byte    in   [7:0] keystream byte
//   ks_ready   out  keystream FIFO can accept a byte
//   pt_valid   in   plaintext byte valid
//   pt_data    in   [7:0] plaintext byte
//   pt_ready   out  plaintext byte consumed when pt_valid & pt_ready
//   ct_valid   out  ciphertext byte valid (registered)
//   ct_data    out  [7:0] ciphertext byte (registered)
//   ct_ready   in   downstream accepts ciphertext
//   busy       out  message in progress
//   done       out  one-cycle pulse at message end
//   byte_cnt   out  [7:0] ciphertext bytes accepted in current message
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing/draining message bytes
// DONE  | one-cycle end-of-message pulse

module rc4_xor_stream #(
  parameter int KS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] msg_len,
  input  logic       flush,
  input  logic       ks_valid,
  input  logic [7:0] ks_byte,
  output logic       ks_ready,
  input  logic       pt_valid,
  input  logic [7:0] pt_data,
  output logic       pt_ready,
  output logic       ct_valid,
  output logic [7:0] ct_data,
  input  logic       ct_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_cnt
);

  localparam int AW = (KS_DEPTH > 2) ? $clog2(KS_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Keystream FIFO
  // The pointers are one bit wider than the address. That extra bit tells
  // full apart from empty when the addresses are equal.
  // ---------------------------------------------------------------------
  logic [7:0]  ks_mem_q [KS_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ks_push;
  logic        ks_pop;
  logic [7:0]  ks_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ks_head    = ks_mem_q[rd_ptr_q[AW-1:0]];

  assign ks_ready = !fifo_full && !flush;
  assign ks_push  = ks_valid && ks_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, ks_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, ks_pop};
    // Flush discards everything still queued. A pop on the same cycle
    // removes only bytes that are being discarded anyway.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ks_push) begin
      ks_mem_q[wr_ptr_q[AW-1:0]] <= ks_byte;
    end
  end

  // ---------------------------------------------------------------------
  // Message control and ciphertext output
  // ---------------------------------------------------------------------
  state_t     state_q;
  logic [7:0] len_q;
  logic [7:0] issued_q;
  logic [7:0] byte_cnt_q;
  logic       ct_valid_q;
  logic [7:0] ct_data_q;
  logic       busy_q;
  logic       done_q;
  logic       pt_fire;
  logic       ct_fire;

  // A new byte may be issued only if the output register will be free at
  // the edge, i.e. it is empty now or is being drained now.
  assign pt_ready = (state_q == RUN) && !fifo_empty && (issued_q < len_q) &&
                    (!ct_valid_q || ct_ready);
  assign pt_fire  = pt_valid && pt_ready;
  assign ks_pop   = pt_fire;
  assign ct_fire  = ct_valid_q && ct_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      byte_cnt_q <= '0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (pt_fire) begin
        ct_data_q  <= pt_data ^ ks_head;
        ct_valid_q <= 1'b1;
        issued_q   <= issued_q + 8'd1;
      end else if (ct_fire) begin
        ct_valid_q <= 1'b0;
      end

      if (ct_fire) begin
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end

      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            len_q      <= msg_len;
            issued_q   <= '0;
            byte_cnt_q <= '0;
            if (msg_len != 8'd0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          // The 8-bit compare wraps, so len 255 ends on the 255th byte.
          if (ct_fire && ((byte_cnt_q + 8'd1) == len_q)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ct_valid = ct_valid_q;
  assign ct_data  = ct_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rc4_xor_stream.sv
module tb_rc4_xor_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] msg_len;
  logic       flush;
  logic       ks_valid;
  logic [7:0] ks_byte;
  logic       ks_ready;
  logic       pt_valid;
  logic [7:0] pt_data;
  logic       pt_ready;
  logic       ct_valid;
  logic [7:0] ct_data;
  logic       ct_ready;
  logic       busy;
  logic       done;
  logic [7:0] byte_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  rc4_xor_stream #(.KS_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .msg_len  (msg_len),
    .flush    (flush),
    .ks_valid (ks_valid),
    .ks_byte  (ks_byte),
    .ks_ready (ks_ready),
    .pt_valid (pt_valid),
    .pt_data  (pt_data),
    .pt_ready (pt_ready),
    .ct_valid (ct_valid),
    .ct_data  (ct_data),
    .ct_ready (ct_ready),
    .busy     (busy),
    .done     (done),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] v [4];
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ks_valid = 1'b1; ks_byte = v[i];
    end
    @(negedge clk); ks_valid = 1'b0;
  endtask

  initial begin
    int ct_n, push_idx, bad;
    bit done_seen;
    rst = 1'b1; start = 0; msg_len = 0; flush = 0; ks_valid = 0; ks_byte = 0;
    pt_valid = 0; pt_data = 0; ct_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ks_ready", ks_ready, 1);
    check("rst_pt_ready", pt_ready, 0);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_ct_data", ct_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byte_cnt", byte_cnt, 0);

    // Basic 3-byte message, full throughput
    push_bytes(8'h11, 8'h22, 8'h33, 8'h00, 3);
    @(negedge clk); start = 1; msg_len = 3;
    @(negedge clk); start = 0; pt_valid = 1; pt_data = 8'hAA; ct_ready = 1;
    #1; check("t1_busy", busy, 1); check("t1_pt_ready", pt_ready, 1);
    @(negedge clk); pt_data = 8'hBB;
    #1; check("t1_ct_valid0", ct_valid, 1); check("t1_ct0", ct_data, 8'hBB);
    @(negedge clk); pt_data = 8'hCC;
    #1; check("t1_ct1", ct_data, 8'h99); check("t1_cnt1", byte_cnt, 1);
    @(negedge clk); pt_valid = 0;
    #1; check("t1_ct2", ct_data, 8'hFF); check("t1_pt_ready_end", pt_ready, 0);
    @(negedge clk);
    #1; check("t1_done", done, 1); check("t1_cnt3", byte_cnt, 3); check("t1_ct_valid_clr", ct_valid, 0);
    @(negedge clk);
    #1; check("t1_done_pulse", done, 0); check("t1_busy_end", busy, 0);

    // Backpressure on ct
    push_bytes(8'h01, 8'h02, 8'h00, 8'h00, 2);
    @(negedge clk); start = 1; msg_len = 2;
    @(negedge clk); start = 0; pt_valid = 1; pt_data = 8'h10; ct_ready = 0;
    #1; check("t2_pt_ready", pt_ready, 1);
    @(negedge clk); pt_data = 8'h20;
    #1; check("t2_ct0", ct_data, 8'h11); check("t2_stall_pt_ready", pt_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1; check("t2_hold_data", ct_data, 8'h11); check("t2_hold_valid", ct_valid, 1);
    end
    @(negedge clk); ct_ready = 1;
    #1; check("t2_resume_pt_ready", pt_ready, 1); check("t2_cnt0", byte_cnt, 0);
    @(negedge clk); pt_valid = 0;
    #1; check("t2_ct1", ct_data, 8'h22); check("t2_cnt1", byte_cnt, 1); check("t2_no_done", done, 0);
    @(negedge clk);
    #1; check("t2_done", done, 1); check("t2_cnt2", byte_cnt, 2);

    // FIFO full: 6 pushes, only 4 accepted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ks_valid = 1; ks_byte = 8'hA0 + 8'(i);
      #1; check("t3_ks_ready", ks_ready, (i < 4) ? 1 : 0);
    end
    @(negedge clk); ks_valid = 0;
    @(negedge clk); start = 1; msg_len = 4;
    @(negedge clk); start = 0; pt_valid = 1; pt_data = 8'h00; ct_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1; check("t3_ct", ct_data, 8'hA0 + 8'(i));
    end
    pt_valid = 0;
    @(negedge clk);
    #1; check("t3_done", done, 1);

    // len=0, then start while busy is ignored
    push_bytes(8'h5A, 8'h00, 8'h00, 8'h00, 1);
    @(negedge clk); start = 1; msg_len = 0;
    @(negedge clk); start = 0;
    #1; check("t4_done", done, 1); check("t4_busy", busy, 0); check("t4_pt_ready", pt_ready, 0);
    @(negedge clk);
    #1; check("t4_done_clr", done, 0);
    @(negedge clk); start = 1; msg_len = 1; pt_valid = 1; pt_data = 8'h00; ct_ready = 1;
    @(negedge clk); start = 1; msg_len = 5;
    #1; check("t4_pt_ready", pt_ready, 1); check("t4_busy_run", busy, 1);
    @(negedge clk); start = 0; pt_valid = 0;
    #1; check("t4_ct", ct_data, 8'h5A); check("t4_issued_cap", pt_ready, 0);
    @(negedge clk);
    #1; check("t4_done2", done, 1); check("t4_cnt", byte_cnt, 1);

    // Empty FIFO stalls RUN, flush discards queued bytes
    @(negedge clk); start = 1; msg_len = 2;
    @(negedge clk); start = 0; pt_valid = 1; pt_data = 8'h0F; ct_ready = 1;
    #1; check("t5_busy", busy, 1); check("t5_empty_stall", pt_ready, 0);
    @(negedge clk); ks_valid = 1; ks_byte = 8'h30;
    #1; check("t5_empty_stall2", pt_ready, 0);
    @(negedge clk); ks_valid = 0;
    #1; check("t5_one_byte", pt_ready, 1);
    @(negedge clk); pt_valid = 0; ks_valid = 1; ks_byte = 8'h40;
    #1; check("t5_ct0", ct_data, 8'h3F); check("t5_empty_again", pt_ready, 0);
    @(negedge clk); ks_byte = 8'h50;
    @(negedge clk); ks_byte = 8'h60; flush = 1;
    #1; check("t5_flush_ks_ready", ks_ready, 0);
    @(negedge clk); flush = 0; ks_valid = 0; pt_valid = 1; pt_data = 8'h0F;
    #1; check("t5_flushed_empty", pt_ready, 0); check("t5_still_busy", busy, 1);
    @(negedge clk); ks_valid = 1; ks_byte = 8'h70;
    @(negedge clk); ks_valid = 0;
    #1; check("t5_refill", pt_ready, 1);
    @(negedge clk); pt_valid = 0;
    #1; check("t5_ct1", ct_data, 8'h7F); check("t5_cnt1", byte_cnt, 1);
    @(negedge clk);
    #1; check("t5_done", done, 1); check("t5_cnt2", byte_cnt, 2);

    // Reset mid-message
    push_bytes(8'h01, 8'h02, 8'h03, 8'h04, 4);
    @(negedge clk); start = 1; msg_len = 4;
    @(negedge clk); start = 0; pt_valid = 1; pt_data = 8'h00; ct_ready = 0;
    @(negedge clk); pt_valid = 0;
    #1; check("t6_ct0", ct_data, 8'h01);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    #1;
    check("t6_ct_valid", ct_valid, 0); check("t6_ct_data", ct_data, 0);
    check("t6_busy", busy, 0); check("t6_done", done, 0);
    check("t6_cnt", byte_cnt, 0); check("t6_ks_ready", ks_ready, 1);
    check("t6_pt_ready", pt_ready, 0);
    push_bytes(8'h99, 8'h00, 8'h00, 8'h00, 1);
    @(negedge clk); start = 1; msg_len = 1;
    @(negedge clk); start = 0; pt_valid = 1; pt_data = 8'h01; ct_ready = 1;
    @(negedge clk); pt_valid = 0;
    #1; check("t6_ct_after", ct_data, 8'h98);
    @(negedge clk);
    #1; check("t6_done_after", done, 1);

    // len=255 with continuous keystream
    ct_n = 0; push_idx = 0; bad = 0; done_seen = 0;
    @(negedge clk); start = 1; msg_len = 8'd255;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk); start = 0; ks_valid = 1; ks_byte = 8'(push_idx);
      pt_valid = 1; pt_data = 8'h00; ct_ready = 1;
      #1;
      if (done) begin done_seen = 1; break; end
      if (ct_valid) begin
        if (ct_data != 8'(ct_n)) bad++;
        ct_n++;
      end
      if (ks_ready) push_idx++;
    end
    check("t7_done_seen", done_seen, 1);
    check("t7_ct_count", ct_n, 255);
    check("t7_ct_errors", bad, 0);
    check("t7_cnt", byte_cnt, 8'd255);
    ks_valid = 0; pt_valid = 0;
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
